// File: rtl/ysyx_23060061_lsu_pkg.sv
//----------------------------------------------------------------------------
// Package : ysyx_23060061_lsu_pkg
// Brief   : Shared state encoding, opcode encodings and misalign check.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package ysyx_23060061_lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] EXT_LB  = 3'b000;
   localparam logic [2:0] EXT_LH  = 3'b001;
   localparam logic [2:0] EXT_LW  = 3'b010;
   localparam logic [2:0] EXT_LBU = 3'b100;
   localparam logic [2:0] EXT_LHU = 3'b101;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   // Loads size themselves by memExt, stores by wmask.
   function automatic logic is_misaligned(input logic [1:0] rw,
                                          input logic [2:0] ext,
                                          input logic [3:0] wmask,
                                          input logic [1:0] addr_lo);
      logic half;
      logic word;
      half = 1'b0;
      word = 1'b0;
      if (rw == RW_READ) begin
         half = (ext == EXT_LH) || (ext == EXT_LHU);
         word = (ext == EXT_LW);
      end else if (rw == RW_WRITE) begin
         half = (wmask == 4'b0011);
         word = (wmask == 4'b1111);
      end
      return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060061_lsu_align.sv
//----------------------------------------------------------------------------
// Module : ysyx_23060061_lsu_align
// Brief  : Combinational store lane shift and load lane extract/extend.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ysyx_23060061_lsu_align
   import ysyx_23060061_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        addr_lo_i,
   input  logic [2:0]        ext_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [3:0]        wmask_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        wstrb_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      wdata_o = wdata_i << {addr_lo_i, 3'b000};
      wstrb_o = wmask_i << addr_lo_i;
      w_byte  = rdata_i[{addr_lo_i, 3'b000} +: 8];
      w_half  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (ext_i)
         EXT_LB:  rdata_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
         EXT_LH:  rdata_o = {{(DATA_W-16){w_half[15]}}, w_half};
         EXT_LW:  rdata_o = rdata_i;
         EXT_LBU: rdata_o = {{(DATA_W-8){1'b0}}, w_byte};
         EXT_LHU: rdata_o = {{(DATA_W-16){1'b0}}, w_half};
         default: rdata_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060061_lsu_hs.sv
//----------------------------------------------------------------------------
// Module : ysyx_23060061_lsu_hs
// Brief  : Handshaked LSU between EXU and WBU with a req/gnt/rvalid port.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ysyx_23060061_lsu_hs
   import ysyx_23060061_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exu_valid,
   output logic              lsu_ready,
   input  logic [2:0]        memExt,
   input  logic [1:0]        MemRW,
   input  logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memDataW,
   input  logic [3:0]        wmask,
   output logic              lsu_valid,
   input  logic              wbu_ready,
   output logic [DATA_W-1:0] memDataR,
   output logic              lsu_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        ext_q, ext_d;
   logic [1:0]        rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] w_wdata_sh;
   logic [3:0]        w_wstrb_sh;
   logic [DATA_W-1:0] w_ld_data;

   ysyx_23060061_lsu_align #(.DATA_W(DATA_W)) u_align (
      .addr_lo_i (addr_q[1:0]),
      .ext_i     (ext_q),
      .wdata_i   (wdata_q),
      .wmask_i   (wmask_q),
      .rdata_i   (mem_rdata),
      .wdata_o   (w_wdata_sh),
      .wstrb_o   (w_wstrb_sh),
      .rdata_o   (w_ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ext_q   <= '0;
         rw_q    <= RW_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ext_q   <= ext_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ext_d   = ext_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (exu_valid) begin
               ext_d   = memExt;
               rw_d    = MemRW;
               addr_d  = memAddr;
               wdata_d = memDataW;
               wmask_d = wmask;
               rdata_d = '0;
               err_d   = is_misaligned(MemRW, memExt, wmask, memAddr[1:0]);
               // MemRW==11 falls into the bypass path like 00.
               if ((MemRW == RW_READ || MemRW == RW_WRITE) && !err_d) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_REQ: begin
            if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (rw_q == RW_READ) rdata_d = w_ld_data;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (wbu_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lsu_ready = (state_q == S_IDLE);
      lsu_valid = (state_q == S_DONE);
      memDataR  = rdata_q;
      lsu_err   = err_q;
      mem_req   = (state_q == S_REQ);
      // Bus fields stay quiet outside the request phase.
      mem_we    = mem_req && (rw_q == RW_WRITE);
      mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      mem_wdata = mem_req ? w_wdata_sh : '0;
      mem_wstrb = mem_req ? w_wstrb_sh : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060061_lsu_hs.sv
//----------------------------------------------------------------------------
// Module : tb_ysyx_23060061_lsu_hs
// Brief  : Self-checking bench for the handshaked LSU.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060061_lsu_hs;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exu_valid = 1'b0;
   logic        lsu_ready;
   logic [2:0]  memExt = '0;
   logic [1:0]  MemRW = '0;
   logic [31:0] memAddr = '0;
   logic [31:0] memDataW = '0;
   logic [3:0]  wmask = '0;
   logic        lsu_valid;
   logic        wbu_ready = 1'b0;
   logic [31:0] memDataR;
   logic        lsu_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   ysyx_23060061_lsu_hs dut (
      .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
      .memExt(memExt), .MemRW(MemRW), .memAddr(memAddr), .memDataW(memDataW),
      .wmask(wmask), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
      .memDataR(memDataR), .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // Drives one operation and plays memory/WBU with the given stall counts.
   // o_lat is the cycle (after acceptance) lsu_valid was first seen, -1 if never.
   task automatic run_op(input logic [1:0] rw, input logic [2:0] ext,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [31:0] rd,
                         input int gd, input int rvd, input int wbd,
                         output logic [31:0] o_data, output logic o_err,
                         output int o_lat, output int o_reqs,
                         output logic o_stable, output logic o_ready_ok,
                         output logic o_we, output logic [31:0] o_addr,
                         output logic [31:0] o_wdata, output logic [3:0] o_wstrb);
      int   cyc, gcnt, rcnt, wcnt;
      logic in_wait, done;
      o_data = '0; o_err = 1'b0; o_lat = -1; o_reqs = 0; o_stable = 1'b1;
      o_ready_ok = 1'b1; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_wstrb = '0;
      cyc = 0; gcnt = 0; rcnt = 0; wcnt = 0; in_wait = 1'b0; done = 1'b0;
      @(negedge clk);
      if (lsu_ready !== 1'b1) o_ready_ok = 1'b0;
      exu_valid = 1'b1; MemRW = rw; memExt = ext; memAddr = addr;
      memDataW = wd; wmask = wm;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         exu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; wbu_ready = 1'b0;
         if (mem_req === 1'b1) begin
            if (o_reqs == 0) begin
               o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
            end else if (mem_we !== o_we || mem_addr !== o_addr ||
                         mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
               o_stable = 1'b0;
            end
            o_reqs++;
            if (gcnt == gd) mem_gnt = 1'b1;
            gcnt++;
         end else if (in_wait) begin
            if (rcnt == rvd) begin
               mem_rvalid = 1'b1; mem_rdata = rd;
            end else begin
               mem_rdata = $urandom;
            end
            rcnt++;
         end else if (lsu_valid === 1'b1) begin
            if (o_lat < 0) begin
               o_lat = cyc; o_data = memDataR; o_err = lsu_err;
            end else if (memDataR !== o_data || lsu_err !== o_err) begin
               o_stable = 1'b0;
            end
            if (lsu_ready !== 1'b0) o_ready_ok = 1'b0;
            if (wcnt == wbd) begin
               wbu_ready = 1'b1; done = 1'b1;
            end
            wcnt++;
         end
         if (mem_gnt) in_wait = 1'b1;
         if (mem_rvalid) in_wait = 1'b0;
      end
      @(negedge clk);
      wbu_ready = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
      if (!done) o_lat = -1;
      if (lsu_ready !== 1'b1 || lsu_valid !== 1'b0) o_ready_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
      total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", lsu_valid); end
      total++; if (lsu_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", lsu_err); end
      total++; if (memDataR !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", memDataR); end
      total++; if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin bad++; $display("FAIL reset_req: got %b want 0", {mem_req, mem_we, mem_wstrb}); end
      total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata}); end
   endtask

   task automatic test_loads();
      logic [2:0]  ext_t [5] = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b100};
      logic [31:0] adr_t [5] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0004, 32'h8000_0002, 32'h8000_0001};
      logic [31:0] rd_t  [5] = '{32'h80FF_1234, 32'h8001_0000, 32'hDEAD_BEEF, 32'hF000_1234, 32'h0000_AB00};
      logic [31:0] exp_t_ [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hDEAD_BEEF, 32'hFFFF_F000, 32'h0000_00AB};
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      for (int i = 0; i < 5; i++) begin
         sb.push_back('{exp_t_[i], 1'b0});
         run_op(2'b01, ext_t[i], adr_t[i], 32'h0, 4'h0, rd_t[i], 0, 0, 0,
                d, e, lat, reqs, st, rk, we, a, wd, ws);
         x = sb.pop_front();
         total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL load%0d_data: got %h/%b want %h/%b", i, d, e, x.data, x.err); end
         total++; if (lat != 3) begin bad++; $display("FAIL load%0d_latency: got %0d want 3", i, lat); end
         total++; if (a !== (adr_t[i] & 32'hFFFF_FFFC) || we !== 1'b0) begin bad++; $display("FAIL load%0d_addr: got %h we %b want %h we 0", i, a, we, adr_t[i] & 32'hFFFF_FFFC); end
      end
   endtask

   task automatic test_stores();
      logic [31:0] adr_t [3] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0008};
      logic [31:0] wd_t  [3] = '{32'h0000_00AB, 32'h0000_BEEF, 32'h1234_5678};
      logic [3:0]  wm_t  [3] = '{4'b0001, 4'b0011, 4'b1111};
      logic [31:0] ewd_t [3] = '{32'h0000_AB00, 32'hBEEF_0000, 32'h1234_5678};
      logic [3:0]  ews_t [3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{32'h0, 1'b0});
         run_op(2'b10, 3'b010, adr_t[i], wd_t[i], wm_t[i], 32'hCAFE_F00D, 0, 0, 0,
                d, e, lat, reqs, st, rk, we, a, wd, ws);
         x = sb.pop_front();
         total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL store%0d_result: got %h/%b want %h/%b", i, d, e, x.data, x.err); end
         total++; if (we !== 1'b1 || ws !== ews_t[i]) begin bad++; $display("FAIL store%0d_strb: got we %b strb %b want we 1 strb %b", i, we, ws, ews_t[i]); end
         total++; if (wd !== ewd_t[i] || a !== (adr_t[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL store%0d_wdata: got %h @%h want %h", i, wd, a, ewd_t[i]); end
         total++; if (lat != 3) begin bad++; $display("FAIL store%0d_latency: got %0d want 3", i, lat); end
      end
   endtask

   task automatic test_bypass_err();
      logic [1:0]  rw_t  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
      logic [31:0] adr_t [4] = '{32'h8000_0002, 32'h8000_0003, 32'h8000_0001, 32'h8000_0000};
      logic [3:0]  wm_t  [4] = '{4'b0000, 4'b1111, 4'b0011, 4'b1111};
      logic        err_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{32'h0, err_t[i]});
         run_op(rw_t[i], 3'b010, adr_t[i], 32'h5555_AAAA, wm_t[i], 32'h1111_2222, 0, 0, 0,
                d, e, lat, reqs, st, rk, we, a, wd, ws);
         x = sb.pop_front();
         total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL bypass%0d_result: got %h/%b want %h/%b", i, d, e, x.data, x.err); end
         total++; if (reqs != 0) begin bad++; $display("FAIL bypass%0d_noreq: got %0d req cycles want 0", i, reqs); end
         total++; if (lat != 1) begin bad++; $display("FAIL bypass%0d_latency: got %0d want 1", i, lat); end
      end
   endtask

   task automatic test_stalls();
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      sb.push_back('{32'hFFFF_A55A, 1'b0});
      run_op(2'b01, 3'b001, 32'h8000_0012, 32'h0, 4'h0, 32'hA55A_0000, 3, 2, 4,
             d, e, lat, reqs, st, rk, we, a, wd, ws);
      x = sb.pop_front();
      total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL stall_data: got %h/%b want %h/%b", d, e, x.data, x.err); end
      total++; if (lat != 8) begin bad++; $display("FAIL stall_latency: got %0d want 8", lat); end
      total++; if (reqs != 4) begin bad++; $display("FAIL stall_req_cycles: got %0d want 4", reqs); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable: got %b want 1", st); end
      total++; if (rk !== 1'b1) begin bad++; $display("FAIL stall_ready: got %b want 1", rk); end
      total++; if (a !== 32'h8000_0010) begin bad++; $display("FAIL stall_addr: got %h want 80000010", a); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] adr_t [3] = '{32'h8000_0020, 32'h8000_0021, 32'h8000_0022};
      logic [2:0]  ext_t [3] = '{3'b010, 3'b100, 3'b000};
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      sb.push_back('{32'h7F80_01FE, 1'b0});
      sb.push_back('{32'h0000_0001, 1'b0});
      sb.push_back('{32'hFFFF_FF80, 1'b0});
      for (int i = 0; i < 3; i++) begin
         run_op(2'b01, ext_t[i], adr_t[i], 32'h0, 4'h0, 32'h7F80_01FE, 0, 0, i,
                d, e, lat, reqs, st, rk, we, a, wd, ws);
         x = sb.pop_front();
         total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL b2b%0d_data: got %h/%b want %h/%b", i, d, e, x.data, x.err); end
         total++; if (rk !== 1'b1 || st !== 1'b1) begin bad++; $display("FAIL b2b%0d_handshake: got ready_ok %b stable %b want 1 1", i, rk, st); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, a, wd; logic e, st, rk, we; int lat, reqs; logic [3:0] ws; exp_t x;
      // Reset while requesting: mem_req must drop without waiting for a clock.
      @(negedge clk);
      exu_valid = 1'b1; MemRW = 2'b01; memExt = 3'b010; memAddr = 32'h8000_0030;
      @(negedge clk);
      exu_valid = 1'b0;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstreq_pre: got %b want 1", mem_req); end
      rst = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rstreq_drop: got req %b addr %h want 0 0", mem_req, mem_addr); end
      @(negedge clk);
      rst = 1'b1;
      // Reset while waiting for the response, then a stray rvalid in IDLE.
      @(negedge clk);
      exu_valid = 1'b1;
      @(negedge clk);
      exu_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst = 1'b0;
      #1;
      total++; if (lsu_ready !== 1'b1 || lsu_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rstwait_ctrl: got rdy %b vld %b req %b want 1 0 0", lsu_ready, lsu_valid, mem_req); end
      total++; if (memDataR !== 32'h0 || lsu_err !== 1'b0) begin bad++; $display("FAIL rstwait_data: got %h/%b want 0/0", memDataR, lsu_err); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      total++; if (lsu_valid !== 1'b0 || lsu_ready !== 1'b1 || memDataR !== 32'h0) begin bad++; $display("FAIL stray_rvalid: got vld %b rdy %b data %h want 0 1 0", lsu_valid, lsu_ready, memDataR); end
      sb.push_back('{32'h0BAD_F00D, 1'b0});
      run_op(2'b01, 3'b010, 32'h8000_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 1, 0,
             d, e, lat, reqs, st, rk, we, a, wd, ws);
      x = sb.pop_front();
      total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL post_reset_lw: got %h/%b want %h/%b", d, e, x.data, x.err); end
      total++; if (lat != 4) begin bad++; $display("FAIL post_reset_latency: got %0d want 4", lat); end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_bypass_err();
      test_stalls();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_23060061_lsu_hs.md
# ysyx_23060061_lsu_hs

Handshaked load/store unit between the EX stage and the WB stage of the multi-cycle NPC core. It accepts one memory operation per transaction over a valid/ready handshake from EXU. It then performs a single request/grant/response access on a data-memory port and returns the aligned, extended load data to WBU over a second valid/ready handshake. Non-memory instructions pass through as a one-cycle bubble, which keeps the stage ordering uniform.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte lanes = 4)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- exu_valid  input  1  EXU holds a valid operation
- lsu_ready  output  1  LSU can accept; high only in IDLE
- memExt  input  3  load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- MemRW  input  2  00 none, 01 read, 10 write, 11 treated as none
- memAddr  input  ADDR_W  byte address
- memDataW  input  DATA_W  store data, LSB-justified
- wmask  input  4  store size mask: 0001 SB, 0011 SH, 1111 SW
- lsu_valid  output  1  result held for WBU
- wbu_ready  input  1  WBU consumes result
- memDataR  output  DATA_W  extended load data; 0 for store/none/error
- lsu_err  output  1  misaligned access; qualified by lsu_valid
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  ADDR_W  word-aligned address (memAddr & ~3)
- mem_wdata  output  DATA_W  memDataW << 8*addr[1:0]
- mem_wstrb  output  4  wmask << addr[1:0]
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  response (read data or write ack)
- mem_rdata  input  DATA_W  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - lsu_ready=1.
  - When exu_valid, capture memExt, MemRW, memAddr, memDataW and wmask.
  - MemRW none: go to DONE with memDataR=0 and lsu_err=0.
  - Misaligned (half access with addr[0]=1, or word access with addr[1:0]!=0; word = LW or wmask 1111): go to DONE with lsu_err=1 and memDataR=0. No memory access is issued.
  - Otherwise: go to REQ.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata/mem_wstrb are driven from the captured registers and stay stable until the grant.
  - mem_gnt: go to WAIT.
- WAIT:
  - mem_req=0.
  - mem_rvalid: for a read, register the extracted data; go to DONE.
  - The response is guaranteed no earlier than the cycle after the grant.
- DONE:
  - lsu_valid=1; memDataR and lsu_err are held stable.
  - wbu_ready: go to IDLE.
- Load extract:
  - The byte or half is selected by addr[1:0] (half uses addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
- Store: the strobe lane bits beyond bit 3 are discarded (the captured address is aligned, so none are lost).
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, lsu_ready=1, lsu_valid=0, lsu_err=0, memDataR=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- Reset mid-transaction: mem_req drops in the same cycle. A late mem_rvalid that arrives in IDLE is dropped.
- Bypass/error path: lsu_valid is high in the cycle after acceptance.
- Memory path, minimum latency: accept at edge 0, REQ with gnt in cycle 1, rvalid in cycle 2, lsu_valid in cycle 3.
  - Each stall cycle of gnt or rvalid adds one cycle.
- Back-to-back: lsu_ready returns the cycle after the wbu_ready handshake, giving at most one operation per 2 cycles.
- memDataR is registered; no combinational path from mem_rdata to memDataR or from wbu_ready to lsu_ready.

## Structure
- Package ysyx_23060061_lsu_pkg holds:
  - the state enum;
  - memExt encodings (LB/LH/LW/LBU/LHU);
  - MemRW encodings (NONE/READ/WRITE);
  - the misalign check as a function.
- Sub-module ysyx_23060061_lsu_align (combinational):
  - store lane shift for wdata/wstrb;
  - load lane extract plus sign/zero extend.
- The FSM, capture registers and output registers stay in the top of this block.

## Test plan
- LB at 0x80000003 with mem_rdata=0x80FF_1234, gnt and rvalid both immediate -> mem_addr=0x80000000, memDataR=0xFFFF_FF80, lsu_valid 3 cycles after acceptance.
- LHU at 0x80000002 with rdata=0x8001_0000 -> memDataR=0x0000_8001. LW at 0x80000004 with rdata=0xDEADBEEF -> memDataR=0xDEADBEEF.
- SB at 0x80000001 with data 0x0000_00AB -> mem_we=1, mem_wstrb=0010, mem_wdata=0x0000_AB00; memDataR=0 at lsu_valid.
- LW at 0x80000002 -> mem_req never asserted; lsu_err=1, lsu_valid 1 cycle after acceptance. MemRW=00 -> lsu_valid next cycle with lsu_err=0.
- gnt stalled 3 cycles, rvalid stalled 2 cycles, wbu_ready low for 4 cycles -> request fields stable throughout, memDataR stable while lsu_valid, and lsu_ready asserted only after the handshake.
- rst asserted in WAIT, then a stray rvalid after release -> outputs at reset values immediately, stray rvalid ignored, next LW completes normally.
